// File: rtl/strength_pkg.sv
// Shared types for the strength-based bus arbiter.
//   strength_t  : 3-bit drive strength code, HIGHZ means "not driving"
//   arb_state_t : arbiter FSM states
//   str_gt      : true when strength a is strictly stronger than b
package strength_pkg;

  typedef enum logic [2:0] {
    HIGHZ  = 3'd0,
    SMALL  = 3'd1,
    MEDIUM = 3'd2,
    WEAK   = 3'd3,
    LARGE  = 3'd4,
    PULL   = 3'd5,
    STRONG = 3'd6,
    SUPPLY = 3'd7
  } strength_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Strength codes are ordered, so an unsigned compare ranks them.
  function automatic logic str_gt(input strength_t a, input strength_t b);
    return (a > b);
  endfunction

endpackage

// File: rtl/strength_pick.sv
// Combinational winner selection for the strength bus arbiter.
//   eligible    : per-requester "wants the net with a non-HIGHZ strength"
//   strength    : packed strength codes, slice i = [3*i +: 3]
//   rr_ptr      : round-robin start index used to break ties
//   winner      : index of the strongest eligible requester
//   winner_str  : strength of that requester (HIGHZ if none)
//   any_valid   : at least one requester is eligible
//   tie_present : more than one eligible requester shares the winning strength
module strength_pick
  import strength_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]   eligible,
  input  logic [3*N_REQ-1:0] strength,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      winner,
  output strength_t          winner_str,
  output logic               any_valid,
  output logic               tie_present
);

  int        idx;
  int        tie_cnt;
  strength_t cand_str;

  // Scan in rotation order starting at rr_ptr; a strict "stronger than"
  // test means the first tied index in rotation order keeps the win.
  always_comb begin
    winner     = '0;
    winner_str = HIGHZ;
    any_valid  = 1'b0;
    idx        = 0;
    cand_str   = HIGHZ;
    for (int k = 0; k < N_REQ; k++) begin
      idx      = (int'(rr_ptr) + k) % N_REQ;
      cand_str = strength_t'(strength[3*idx +: 3]);
      if (eligible[idx] && (!any_valid || str_gt(cand_str, winner_str))) begin
        any_valid  = 1'b1;
        winner     = IW'(idx);
        winner_str = cand_str;
      end
    end
  end

  // A tie exists when the winning strength is shared by another eligible peer.
  always_comb begin
    tie_cnt = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (eligible[i] && (strength[3*i +: 3] == winner_str)) begin
        tie_cnt = tie_cnt + 1;
      end
    end
    tie_present = (tie_cnt > 1);
  end

endmodule

// File: rtl/strength_bus_arbiter.sv
// Strength-based arbiter for one shared output net.
// The strongest eligible requester owns the net; equal strengths rotate
// round-robin, and every ownership change passes through a one-cycle GAP so
// two drivers never overlap.
//   clk, rst_n    : clock, asynchronous active-low reset
//   req           : request level per requester
//   strength      : strength code per requester, slice i = [3*i +: 3]
//   data          : drive value per requester, slice i = [DW*i +: DW]
//   gnt           : registered one-hot grant (zero when idle/gap)
//   bus_o         : registered net value, holds through GAP/IDLE
//   bus_valid     : net is driven (|gnt)
//   bus_strength  : strength of the current owner, HIGHZ when undriven
//   preempt       : one-cycle pulse when the owner lost to a stronger requester
module strength_bus_arbiter
  import strength_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [3*N_REQ-1:0]  strength,
  input  logic [DW*N_REQ-1:0] data,
  output logic [N_REQ-1:0]    gnt,
  output logic [DW-1:0]       bus_o,
  output logic                bus_valid,
  output logic [2:0]          bus_strength,
  output logic                preempt
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [DW-1:0]    bus_q, bus_d;
  strength_t        str_q, str_d;
  logic             preempt_q, preempt_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic [N_REQ-1:0] eligible;
  logic [IW-1:0]    win_idx;
  strength_t        win_str;
  logic             any_valid;
  logic             tie_present;
  strength_t        owner_str;
  logic             owner_elig;

  // A HIGHZ strength is treated exactly like a dropped request.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req[i] && (strength[3*i +: 3] != HIGHZ);
    end
  end

  strength_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .eligible   (eligible),
    .strength   (strength),
    .rr_ptr     (rr_q),
    .winner     (win_idx),
    .winner_str (win_str),
    .any_valid  (any_valid),
    .tie_present(tie_present)
  );

  assign owner_str  = strength_t'(strength[3*int'(owner_q) +: 3]);
  assign owner_elig = eligible[owner_q];

  // While granted, the owner is eligible and not outranked, so it holds the
  // maximum strength; tie_present then means an equal peer is waiting.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    bus_d     = bus_q;
    str_d     = str_q;
    preempt_d = 1'b0;
    rr_d      = rr_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE, GAP: begin
        if (any_valid) begin
          state_d = GRANT;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d = win_idx;
          bus_d   = data[DW*int'(win_idx) +: DW];
          str_d   = win_str;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          str_d   = HIGHZ;
        end
      end
      GRANT: begin
        if (!owner_elig || str_gt(win_str, owner_str) ||
            ((hold_q == HW'(MAX_HOLD-1)) && tie_present)) begin
          state_d   = GAP;
          gnt_d     = '0;
          str_d     = HIGHZ;
          preempt_d = owner_elig && str_gt(win_str, owner_str);
          rr_d      = (owner_q == IW'(N_REQ-1)) ? '0 : owner_q + 1'b1;
        end else begin
          bus_d = data[DW*int'(owner_q) +: DW];
          str_d = owner_str;
          if (hold_q != HW'(MAX_HOLD-1)) begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        str_d   = HIGHZ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      bus_q     <= '0;
      str_q     <= HIGHZ;
      preempt_q <= 1'b0;
      rr_q      <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      bus_q     <= bus_d;
      str_q     <= str_d;
      preempt_q <= preempt_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt          = gnt_q;
  assign bus_o        = bus_q;
  assign bus_valid    = |gnt_q;
  assign bus_strength = str_q;
  assign preempt      = preempt_q;

endmodule
